// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 encryption sequencer:
// block width, round count, round-index type and controller FSM states.
package aes_pkg;

  localparam int AES_DW = 128;
  localparam int AES_NR = 10;

  // Round index as seen by the key schedule (0 = initial AddRoundKey key).
  typedef logic [3:0] round_t;

  // Controller states: waiting for a block, iterating rounds, holding result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

endpackage : aes_pkg

// File: rtl/aes_round_counter.sv
// Round counter for the AES sequencer: load-to-1 on block acceptance,
// increment once per round, clear at the end of encryption or on abort.
// The terminal flag marks the final round (no mixColumns) and ends the
// round loop in the controller.
module aes_round_counter
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] round,
  output logic       last
);

  round_t count;

  // Counter register: clear beats load beats increment; saturates at NR.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= 4'd1;
    end else if (inc && (count != round_t'(NR))) begin
      count <= count + 4'd1;
    end
  end

  assign round = count;
  assign last  = (count == round_t'(NR));

endmodule : aes_round_counter

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer. Accepts a plaintext block on a
// valid/ready handshake, applies the initial AddRoundKey, then drives the
// external round datapath for rounds 1..NR (one per clock) and presents the
// ciphertext on a valid/ready output until the consumer takes it.
// Optional feature: define AES_ROUND_CTRL_ABORT_EN to add an 'abort' input
// that discards the block in flight (ROUND or DONE) and returns to IDLE.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int DW = AES_DW
) (
  input  logic          clk,
  input  logic          rst,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [3:0]    rk_idx,
  input  logic [DW-1:0] rk_in,
  output logic [DW-1:0] dp_state,
  output logic          dp_final,
  input  logic [DW-1:0] dp_result,
  output logic          busy
);

  ctrl_state_t   fsm, fsm_nxt;
  logic [DW-1:0] blk, blk_nxt;
  logic          cnt_load, cnt_inc, cnt_clr;
  logic [3:0]    round;
  logic          last;
  logic          abort_hit;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_hit = abort && (fsm != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  aes_round_counter #(
    .NR (NR)
  ) u_round_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .round (round),
    .last  (last)
  );

  // FSM and AES state register; reset discards any block in flight.
  always_ff @(posedge clk) begin
    // NOTE: the wide state register is reset on purpose so out_data reads 0
    // after reset instead of leaking the previous (possibly secret) block.
    if (rst) begin
      fsm <= IDLE;
      blk <= '0;
    end else begin
      fsm <= fsm_nxt;
      blk <= blk_nxt;
    end
  end

  // Next-state, state-register update and counter control.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a branch that
    // forgets one would otherwise infer a latch.
    fsm_nxt  = fsm;
    blk_nxt  = blk;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    case (fsm)
      IDLE: begin
        if (in_valid) begin
          blk_nxt  = in_data ^ rk_in;
          cnt_load = 1'b1;
          fsm_nxt  = ROUND;
        end
      end
      ROUND: begin
        blk_nxt = dp_result;
        if (last) begin
          cnt_clr = 1'b1;
          fsm_nxt = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_nxt = IDLE;
        end
      end
      default: begin
        fsm_nxt = IDLE;
      end
    endcase
    // Abort wins over the round update and the output handshake.
    if (abort_hit) begin
      fsm_nxt = IDLE;
      blk_nxt = '0;
      cnt_clr = 1'b1;
    end
  end

  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm != IDLE);
  assign rk_idx    = (fsm == ROUND) ? round : 4'd0;
  assign dp_final  = (fsm == ROUND) && last;
  assign dp_state  = blk;
  assign out_data  = blk;

endmodule : aes_round_ctrl
